// File: rtl/step_pulse_scheduler_pkg.sv
// Shared defaults and state encoding for the step pulse scheduler.
package step_pulse_scheduler_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/step_pulse_scheduler_if.sv
// Move-command handshake between the profile generator and the step pulse scheduler.
interface step_pulse_scheduler_if
    import step_pulse_scheduler_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_period;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_period,
        output cmd_steps,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_period,
        input  cmd_steps,
        input  cmd_dir,
        output cmd_ready
    );

endinterface

// File: rtl/step_pulse_scheduler_counter.sv
// Step-period up-counter; clear has priority over enable.
module step_pulse_scheduler_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/step_pulse_scheduler.sv
// Emits fixed-width step pulses spaced by the commanded period for the commanded step count.
//
// state | meaning
// IDLE  | ready for a command; rejects illegal periods, zero-step moves finish at once
// SETUP | dir_out settling for DIR_SETUP cycles before the first pulse
// RUN   | counter runs 0..period-1 per step, step_out high for the first PULSE_W counts
// DONE  | one-cycle done pulse, then back to IDLE
module step_pulse_scheduler
    import step_pulse_scheduler_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    step_pulse_scheduler_if.slave cmd,
    input  logic                  abort,
    output logic                  step_out,
    output logic                  dir_out,
    output logic                  busy,
    output logic [CNT_W-1:0]      steps_left,
    output logic                  done,
    output logic                  aborted,
    output logic                  err
);

    localparam int               SW         = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(PULSE_W + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [SW-1:0]    SETUP_LOAD = SW'(DIR_SETUP - 1);

    state_t           state;
    logic             ready_q;
    logic [CNT_W-1:0] period_m1;
    logic [CNT_W-1:0] count;
    logic [SW-1:0]    setup_cnt;
    logic             accept;
    logic             period_end;
    logic             cnt_en;
    logic             cnt_clr;

    // abort blocks acceptance combinationally so an abort never races a new command in
    assign cmd.cmd_ready = ready_q & ~abort;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign period_end    = (count == period_m1);
    assign cnt_en        = (state == ST_RUN);
    assign cnt_clr       = (state != ST_RUN) | abort | period_end;

    step_pulse_scheduler_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ready_q    <= 1'b1;
            step_out   <= 1'b0;
            dir_out    <= 1'b0;
            busy       <= 1'b0;
            steps_left <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
            period_m1  <= '0;
            setup_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd.cmd_period < MIN_PERIOD) begin
                            err <= 1'b1;
                        end else if (cmd.cmd_steps == '0) begin
                            state   <= ST_DONE;
                            ready_q <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state      <= ST_SETUP;
                            ready_q    <= 1'b0;
                            busy       <= 1'b1;
                            dir_out    <= cmd.cmd_dir;
                            steps_left <= cmd.cmd_steps;
                            period_m1  <= cmd.cmd_period - CNT_W'(1);
                            setup_cnt  <= SETUP_LOAD;
                        end
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (setup_cnt == '0) begin
                        state      <= ST_RUN;
                        step_out   <= 1'b1;
                        steps_left <= steps_left - CNT_W'(1);
                    end else begin
                        setup_cnt <= setup_cnt - SW'(1);
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        ready_q  <= 1'b1;
                        busy     <= 1'b0;
                        step_out <= 1'b0;
                        aborted  <= 1'b1;
                    end else if (period_end) begin
                        if (steps_left == '0) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            step_out <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            step_out   <= 1'b1;
                            steps_left <= steps_left - CNT_W'(1);
                        end
                    end else begin
                        // registered: high on the next count when it is still below PULSE_W
                        step_out <= (count < PULSE_LAST);
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
